// File: rtl/trigger_scheduler.sv
// rtl/trigger_scheduler.sv - sw/ext/periodic trigger arbiter with dead time and trigger statistics
// Define TRG_SCHED_PERIODIC_EN to build in the periodic trigger generator.
module trigger_scheduler #(
   parameter int DEADTIME = 3,
   parameter int CNT_W    = 16,
   parameter int PER_W    = 16
) (
   input  logic             clk80,
   input  logic             reset,
   input  logic             sync,
   input  logic             enable,
   input  logic [2:0]       src_en,
   input  logic             busy,
   input  logic [4:0]       ext_evt,
   input  logic [3:0]       ext_pos,
   input  logic [4:0]       sw_cmd,
   input  logic             sw_valid,
   output logic             sw_ready,
   input  logic [PER_W-1:0] per_period,
   input  logic             clr_cnt,
   output logic [4:0]       trigger_out,
   output logic [3:0]       trigger_pos,
   output logic [CNT_W-1:0] cnt_acc,
   output logic [CNT_W-1:0] cnt_lost,
   output logic             dead
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;
   localparam logic [3:0] DCNT_INIT = 4'(DEADTIME - 1);

   state_t           state_q, state_d;
   logic [3:0]       dcnt_q, dcnt_d;
   logic [4:0]       trigger_out_q, trigger_out_d;
   logic [3:0]       trigger_pos_q, trigger_pos_d;
   logic             dead_q, dead_d;
   logic             sw_ready_q, sw_ready_d;
   logic [4:0]       sw_cmd_q, sw_cmd_d;
   logic [CNT_W-1:0] cnt_acc_q, cnt_acc_d;
   logic [CNT_W-1:0] cnt_lost_q, cnt_lost_d;

   logic       fire;
   logic       sw_req, ext_req, per_req, run_ok;
   logic       issue_sw, issue_ext, issue_per, issue, lost;
   logic [4:0] sel_evt;

`ifdef TRG_SCHED_PERIODIC_EN
   logic [PER_W-1:0] pcnt_q, pcnt_d;

   // Counter runs only outside IDLE; a period lowered below the count wraps without firing.
   always_comb begin
      fire   = (state_q != ST_IDLE) && (per_period != '0) && (pcnt_q == per_period - PER_W'(1));
      pcnt_d = pcnt_q;
      if (sync) begin
         if (state_q == ST_IDLE || per_period == '0 || pcnt_q >= per_period - PER_W'(1))
            pcnt_d = '0;
         else
            pcnt_d = pcnt_q + PER_W'(1);
      end
   end

   always_ff @(posedge clk80 or posedge reset) begin
      if (reset) pcnt_q <= '0;
      else       pcnt_q <= pcnt_d;
   end
`else
   logic unused_per_period;
   assign unused_per_period = ^per_period;
   assign fire = 1'b0;
`endif

   // busy vetoes only the physics sources; a queued software command always goes out.
   assign sw_req    = !sw_ready_q && src_en[1];
   assign ext_req   = (ext_evt != 5'd0) && src_en[0] && !busy;
   assign per_req   = fire && src_en[2] && !busy;
   assign run_ok    = (state_q == ST_RUN) && enable;
   assign issue_sw  = run_ok && sw_req;
   assign issue_ext = run_ok && !sw_req && ext_req;
   assign issue_per = run_ok && !sw_req && !ext_req && per_req;
   assign issue     = issue_sw || issue_ext || issue_per;
   assign sel_evt   = issue_sw  ? sw_cmd_q :
                      issue_ext ? ext_evt  :
                      issue_per ? 5'b00010 : 5'b00000;
   assign lost      = (state_q != ST_IDLE) &&
                      ((ext_evt[1] && src_en[0] && !issue_ext) || (fire && src_en[2] && !issue_per));

   always_ff @(posedge clk80 or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      if (sync) begin
         if (!enable) begin
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: state_d = ST_RUN;
               ST_RUN: begin
                  if (issue) begin
                     state_d = ST_DEAD;
                     dcnt_d  = DCNT_INIT;
                  end
               end
               ST_DEAD: begin
                  if (dcnt_q == 4'd0) state_d = ST_RUN;
                  else                dcnt_d  = dcnt_q - 4'd1;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      trigger_out_d = trigger_out_q;
      trigger_pos_d = trigger_pos_q;
      dead_d        = dead_q;
      if (sync) begin
         trigger_out_d = sel_evt;
         trigger_pos_d = issue_ext ? ext_pos : 4'd0;
         dead_d        = (state_d == ST_DEAD);
      end

      sw_ready_d = sw_ready_q;
      sw_cmd_d   = sw_cmd_q;
      if (sync && issue_sw) begin
         sw_ready_d = 1'b1;
      end else if (sw_ready_q && sw_valid && sw_cmd != 5'd0) begin
         sw_cmd_d   = sw_cmd;
         sw_ready_d = 1'b0;
      end

      cnt_acc_d  = cnt_acc_q;
      cnt_lost_d = cnt_lost_q;
      if (clr_cnt) begin
         cnt_acc_d  = '0;
         cnt_lost_d = '0;
      end else if (sync) begin
         if (sel_evt[1] && cnt_acc_q != '1) cnt_acc_d  = cnt_acc_q + CNT_W'(1);
         if (lost && cnt_lost_q != '1)      cnt_lost_d = cnt_lost_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk80 or posedge reset) begin
      if (reset) begin
         trigger_out_q <= 5'd0;
         trigger_pos_q <= 4'd0;
         dead_q        <= 1'b0;
         sw_ready_q    <= 1'b1;
         sw_cmd_q      <= 5'd0;
         cnt_acc_q     <= '0;
         cnt_lost_q    <= '0;
      end else begin
         trigger_out_q <= trigger_out_d;
         trigger_pos_q <= trigger_pos_d;
         dead_q        <= dead_d;
         sw_ready_q    <= sw_ready_d;
         sw_cmd_q      <= sw_cmd_d;
         cnt_acc_q     <= cnt_acc_d;
         cnt_lost_q    <= cnt_lost_d;
      end
   end

   assign trigger_out = trigger_out_q;
   assign trigger_pos = trigger_pos_q;
   assign dead        = dead_q;
   assign sw_ready    = sw_ready_q;
   assign cnt_acc     = cnt_acc_q;
   assign cnt_lost    = cnt_lost_q;

endmodule

// File: tb/tb_trigger_scheduler.sv
// tb/tb_trigger_scheduler.sv - bench for trigger_scheduler, directed scenarios plus random run against a model
// Define TRG_SCHED_PERIODIC_EN for both files to cover the periodic generator.
module tb_trigger_scheduler;
   localparam int DEADTIME = 3;
   localparam int CNT_W    = 8;
   localparam int PER_W    = 16;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk80 = 1'b0;
   logic             reset = 1'b1;
   logic             sync, enable, busy, sw_valid, clr_cnt;
   logic [2:0]       src_en;
   logic [4:0]       ext_evt, sw_cmd;
   logic [3:0]       ext_pos;
   logic [PER_W-1:0] per_period;
   logic             sw_ready, dead;
   logic [4:0]       trigger_out;
   logic [3:0]       trigger_pos;
   logic [CNT_W-1:0] cnt_acc, cnt_lost;

   int n_vec = 0;
   int n_err = 0;

   // reference model: running flag, ticks still blocked, pending sw command, integer counters
   bit         m_run;
   int         m_block;
   bit         m_pend;
   logic [4:0] m_cmd;
   int         m_pcnt;
   int         m_acc, m_lost;
   logic [4:0] e_out;
   logic [3:0] e_pos;
   bit         e_dead;

   trigger_scheduler #(.DEADTIME(DEADTIME), .CNT_W(CNT_W), .PER_W(PER_W)) dut (
      .clk80(clk80), .reset(reset), .sync(sync), .enable(enable), .src_en(src_en),
      .busy(busy), .ext_evt(ext_evt), .ext_pos(ext_pos), .sw_cmd(sw_cmd),
      .sw_valid(sw_valid), .sw_ready(sw_ready), .per_period(per_period),
      .clr_cnt(clr_cnt), .trigger_out(trigger_out), .trigger_pos(trigger_pos),
      .cnt_acc(cnt_acc), .cnt_lost(cnt_lost), .dead(dead)
   );

   always #5 clk80 = ~clk80;

   task automatic model_reset();
      m_run = 0; m_block = 0; m_pend = 0; m_cmd = 5'd0; m_pcnt = 0;
      m_acc = 0; m_lost = 0; e_out = 5'd0; e_pos = 4'd0; e_dead = 0;
   endtask

   task automatic model_step();
      int src;
      bit fire;
      bit pend_was;
      if (reset) begin
         model_reset();
         return;
      end
      pend_was = m_pend;
      src = 0;
      fire = 0;
      if (sync) begin
`ifdef TRG_SCHED_PERIODIC_EN
         fire = m_run && per_period != 0 && m_pcnt == int'(per_period) - 1;
`endif
         if (m_run && m_block == 0 && enable) begin
            if (m_pend && src_en[1])                         src = 1;
            else if (ext_evt != 0 && src_en[0] && !busy)     src = 2;
            else if (fire && src_en[2] && !busy)             src = 3;
         end
         if (m_run && ((ext_evt[1] && src_en[0] && src != 2) || (fire && src_en[2] && src != 3)))
            m_lost = (m_lost < CNT_MAX) ? m_lost + 1 : CNT_MAX;
         e_out = (src == 1) ? m_cmd : (src == 2) ? ext_evt : (src == 3) ? 5'b00010 : 5'b00000;
         e_pos = (src == 2) ? ext_pos : 4'd0;
         if (e_out[1]) m_acc = (m_acc < CNT_MAX) ? m_acc + 1 : CNT_MAX;
         if (src == 1) m_pend = 0;
`ifdef TRG_SCHED_PERIODIC_EN
         m_pcnt = (!m_run || per_period == 0 || m_pcnt + 1 >= int'(per_period)) ? 0 : m_pcnt + 1;
`endif
         if (!enable) begin
            m_run = 0;
            m_block = 0;
         end else if (!m_run) m_run = 1;
         else if (src != 0)   m_block = DEADTIME;
         else if (m_block > 0) m_block--;
         e_dead = (m_block > 0);
      end
      if (!pend_was && sw_valid && sw_cmd != 0) begin
         m_pend = 1;
         m_cmd = sw_cmd;
      end
      if (clr_cnt) begin
         m_acc = 0;
         m_lost = 0;
      end
   endtask

   task automatic step();
      @(posedge clk80);
      model_step();
      #1;
   endtask

   task automatic sync_tick();
      sync = 1'b1;
      step();
      sync = 1'b0;
      step();
   endtask

   task automatic clear_inputs();
      sync = 0; enable = 0; busy = 0; sw_valid = 0; clr_cnt = 0;
      src_en = 3'b000; ext_evt = 5'd0; sw_cmd = 5'd0; ext_pos = 4'd0; per_period = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      model_reset();
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (trigger_out !== 5'd0) begin n_err++; $display("FAIL reset trigger_out got %b want 00000", trigger_out); end
      n_vec++; if (trigger_pos !== 4'd0) begin n_err++; $display("FAIL reset trigger_pos got %0d want 0", trigger_pos); end
      n_vec++; if (cnt_acc !== 0) begin n_err++; $display("FAIL reset cnt_acc got %0d want 0", cnt_acc); end
      n_vec++; if (cnt_lost !== 0) begin n_err++; $display("FAIL reset cnt_lost got %0d want 0", cnt_lost); end
      n_vec++; if (dead !== 1'b0) begin n_err++; $display("FAIL reset dead got %b want 0", dead); end
      n_vec++; if (sw_ready !== 1'b1) begin n_err++; $display("FAIL reset sw_ready got %b want 1", sw_ready); end
   endtask

   task automatic test_ext_single();
      do_reset();
      enable = 1; src_en = 3'b001;
      sync_tick();
      ext_evt = 5'b00010; ext_pos = 4'd7;
      sync_tick();
      ext_evt = 5'd0; ext_pos = 4'd0;
      n_vec++; if (trigger_out !== 5'b00010) begin n_err++; $display("FAIL ext_single trigger_out got %b want 00010", trigger_out); end
      n_vec++; if (trigger_pos !== 4'd7) begin n_err++; $display("FAIL ext_single trigger_pos got %0d want 7", trigger_pos); end
      n_vec++; if (cnt_acc !== 1) begin n_err++; $display("FAIL ext_single cnt_acc got %0d want 1", cnt_acc); end
      n_vec++; if (dead !== 1'b1) begin n_err++; $display("FAIL ext_single dead t0 got %b want 1", dead); end
      for (int t = 1; t <= 3; t++) begin
         sync_tick();
         n_vec++;
         if (dead !== (t < 3)) begin n_err++; $display("FAIL ext_single dead t%0d got %b want %b", t, dead, t < 3); end
         n_vec++;
         if (trigger_out !== 5'd0) begin n_err++; $display("FAIL ext_single hold t%0d got %b want 00000", t, trigger_out); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      enable = 1; src_en = 3'b001;
      sync_tick();
      ext_evt = 5'b00010; sync_tick();
      ext_evt = 5'd0;     sync_tick();
      ext_evt = 5'b00010; sync_tick();
      n_vec++; if (trigger_out !== 5'd0) begin n_err++; $display("FAIL b2b second trigger_out got %b want 00000", trigger_out); end
      ext_evt = 5'd0;
      for (int t = 0; t < 4; t++) sync_tick();
      n_vec++; if (cnt_acc !== 1) begin n_err++; $display("FAIL b2b cnt_acc got %0d want 1", cnt_acc); end
      n_vec++; if (cnt_lost !== 1) begin n_err++; $display("FAIL b2b cnt_lost got %0d want 1", cnt_lost); end
   endtask

   task automatic test_sw_priority();
      do_reset();
      enable = 1; src_en = 3'b011; busy = 1;
      sync_tick();
      sw_cmd = 5'd0; sw_valid = 1; step();
      n_vec++; if (sw_ready !== 1'b1) begin n_err++; $display("FAIL sw_zero sw_ready got %b want 1", sw_ready); end
      sw_cmd = 5'b01000; step();
      n_vec++; if (sw_ready !== 1'b0) begin n_err++; $display("FAIL sw_latch sw_ready got %b want 0", sw_ready); end
      sw_cmd = 5'b00001; step();
      sw_valid = 0; sw_cmd = 5'd0;
      ext_evt = 5'b00010; ext_pos = 4'd9;
      sync_tick();
      ext_evt = 5'd0; ext_pos = 4'd0;
      n_vec++; if (trigger_out !== 5'b01000) begin n_err++; $display("FAIL sw_prio trigger_out got %b want 01000", trigger_out); end
      n_vec++; if (trigger_pos !== 4'd0) begin n_err++; $display("FAIL sw_prio trigger_pos got %0d want 0", trigger_pos); end
      n_vec++; if (sw_ready !== 1'b1) begin n_err++; $display("FAIL sw_prio sw_ready got %b want 1", sw_ready); end
      n_vec++; if (cnt_lost !== 1) begin n_err++; $display("FAIL sw_prio cnt_lost got %0d want 1", cnt_lost); end
      n_vec++; if (cnt_acc !== 0) begin n_err++; $display("FAIL sw_prio cnt_acc got %0d want 0", cnt_acc); end
      busy = 0;
      for (int t = 0; t < 6; t++) begin
         sync_tick();
         n_vec++;
         if (trigger_out !== 5'd0) begin n_err++; $display("FAIL sw_ignored t%0d trigger_out got %b want 00000", t, trigger_out); end
      end
   endtask

   task automatic test_periodic();
      int n_evt, last, exp_evt;
`ifdef TRG_SCHED_PERIODIC_EN
      exp_evt = 10;
`else
      exp_evt = 0;
`endif
      do_reset();
      enable = 1; src_en = 3'b100; per_period = 16'd10;
      sync_tick();
      n_evt = 0; last = -1;
      for (int t = 1; t <= 100; t++) begin
         sync_tick();
         if (trigger_out !== 5'd0) begin
            n_vec++;
            if (trigger_out !== 5'b00010) begin n_err++; $display("FAIL per_bits t%0d got %b want 00010", t, trigger_out); end
            if (last >= 0) begin
               n_vec++;
               if (t - last != 10) begin n_err++; $display("FAIL per_spacing t%0d got %0d want 10", t, t - last); end
            end
            last = t;
            n_evt++;
         end
      end
      n_vec++; if (n_evt != exp_evt) begin n_err++; $display("FAIL per_count got %0d want %0d", n_evt, exp_evt); end
      n_vec++; if (cnt_acc !== CNT_W'(exp_evt)) begin n_err++; $display("FAIL per_cnt_acc got %0d want %0d", cnt_acc, exp_evt); end
      per_period = '0;
      n_evt = 0;
      for (int t = 0; t < 30; t++) begin
         sync_tick();
         if (trigger_out !== 5'd0) n_evt++;
      end
      n_vec++; if (n_evt != 0) begin n_err++; $display("FAIL per_off count got %0d want 0", n_evt); end
   endtask

   task automatic test_saturation();
      do_reset();
      enable = 1; src_en = 3'b001; busy = 1; ext_evt = 5'b00010;
      for (int t = 0; t < 300; t++) sync_tick();
      n_vec++; if (cnt_lost !== CNT_W'(CNT_MAX)) begin n_err++; $display("FAIL sat cnt_lost got %0d want %0d", cnt_lost, CNT_MAX); end
      sync_tick();
      sync_tick();
      n_vec++; if (cnt_lost !== CNT_W'(CNT_MAX)) begin n_err++; $display("FAIL sat_hold cnt_lost got %0d want %0d", cnt_lost, CNT_MAX); end
      clr_cnt = 1; sync = 1; step();
      clr_cnt = 0; sync = 0;
      n_vec++; if (cnt_lost !== 0) begin n_err++; $display("FAIL clr_vs_loss cnt_lost got %0d want 0", cnt_lost); end
      step();
      sync_tick();
      n_vec++; if (cnt_lost !== 1) begin n_err++; $display("FAIL after_clr cnt_lost got %0d want 1", cnt_lost); end
   endtask

   task automatic test_reset_mid_dead();
      do_reset();
      enable = 1; src_en = 3'b011;
      sync_tick();
      ext_evt = 5'b00010; sync_tick();
      ext_evt = 5'd0;
      sw_cmd = 5'b00100; sw_valid = 1; step();
      sw_valid = 0; sw_cmd = 5'd0;
      n_vec++; if (dead !== 1'b1 || sw_ready !== 1'b0) begin n_err++; $display("FAIL mid_dead setup dead=%b sw_ready=%b want 1 0", dead, sw_ready); end
      reset = 1'b1;
      model_reset();
      #2;
      n_vec++; if (trigger_out !== 5'd0) begin n_err++; $display("FAIL rst_async trigger_out got %b want 00000", trigger_out); end
      n_vec++; if (sw_ready !== 1'b1) begin n_err++; $display("FAIL rst_async sw_ready got %b want 1", sw_ready); end
      n_vec++; if (dead !== 1'b0) begin n_err++; $display("FAIL rst_async dead got %b want 0", dead); end
      n_vec++; if (cnt_acc !== 0) begin n_err++; $display("FAIL rst_async cnt_acc got %0d want 0", cnt_acc); end
      step();
      reset = 1'b0;
      enable = 0; src_en = 3'b001; ext_evt = 5'b00010; ext_pos = 4'd5;
      sync_tick();
      n_vec++; if (trigger_out !== 5'd0) begin n_err++; $display("FAIL rst_idle trigger_out got %b want 00000", trigger_out); end
      enable = 1;
      sync_tick();
      sync_tick();
      n_vec++; if (trigger_out !== 5'b00010) begin n_err++; $display("FAIL rst_first trigger_out got %b want 00010", trigger_out); end
      n_vec++; if (trigger_pos !== 4'd5) begin n_err++; $display("FAIL rst_first trigger_pos got %0d want 5", trigger_pos); end
      n_vec++; if (cnt_lost !== 0) begin n_err++; $display("FAIL rst_first cnt_lost got %0d want 0", cnt_lost); end
      ext_evt = 5'd0; ext_pos = 4'd0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         sync     = (c % 2 == 0);
         enable   = ($urandom % 32) != 0;
         src_en   = 3'($urandom);
         busy     = ($urandom % 4) == 0;
         ext_evt  = (($urandom % 3) == 0) ? 5'($urandom) : 5'd0;
         ext_pos  = 4'($urandom);
         sw_valid = ($urandom % 6) == 0;
         sw_cmd   = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
         clr_cnt  = ($urandom % 150) == 0;
         if (c % 200 == 0) per_period = PER_W'($urandom_range(0, 12));
         step();
         n_vec++; if (trigger_out !== e_out) begin n_err++; $display("FAIL rnd trigger_out cyc %0d got %b want %b", c, trigger_out, e_out); end
         n_vec++; if (trigger_pos !== e_pos) begin n_err++; $display("FAIL rnd trigger_pos cyc %0d got %0d want %0d", c, trigger_pos, e_pos); end
         n_vec++; if (dead !== e_dead) begin n_err++; $display("FAIL rnd dead cyc %0d got %b want %b", c, dead, e_dead); end
         n_vec++; if (sw_ready !== !m_pend) begin n_err++; $display("FAIL rnd sw_ready cyc %0d got %b want %b", c, sw_ready, !m_pend); end
         n_vec++; if (cnt_acc !== CNT_W'(m_acc)) begin n_err++; $display("FAIL rnd cnt_acc cyc %0d got %0d want %0d", c, cnt_acc, m_acc); end
         n_vec++; if (cnt_lost !== CNT_W'(m_lost)) begin n_err++; $display("FAIL rnd cnt_lost cyc %0d got %0d want %0d", c, cnt_lost, m_lost); end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      test_reset();
      test_ext_single();
      test_back_to_back();
      test_sw_priority();
      test_periodic();
      test_saturation();
      test_reset_mid_dead();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/trigger_scheduler.md
Name: trigger_scheduler

Overview:
- Arbitrates three trigger/command sources onto the single 5-bit event bus and sequences dead time after each issued event.
- Sources: the async external trigger front end, the software command register, and an internal periodic generator.
- Sits in the clk80 domain, after the external trigger sampler and before the event/command encoder.
- Advances only on sync ticks (40 MHz qualifier) and keeps accepted/lost trigger statistics.

Parameters:
- DEADTIME, 3, sync ticks blocked after any issued event (1..15).
- CNT_W, 16, width of the accepted and lost counters.
- PER_W, 16, width of the periodic generator period.

Ports:
- clk80  in  1  system clock, 80 MHz
- reset  in  1  asynchronous, active-high reset
- sync  in  1  40 MHz tick qualifier; all state advances only when sync=1
- enable  in  1  scheduler run enable
- src_en  in  3  source enables: [0] ext, [1] sw, [2] periodic
- busy  in  1  downstream readout busy; vetoes ext/periodic triggers
- ext_evt  in  5  external event bits from the sampler
- ext_pos  in  4  external trigger sub-phase position
- sw_cmd  in  5  software event bits
- sw_valid  in  1  one-cycle software command strobe
- sw_ready  out  1  software holding register free
- per_period  in  PER_W  periodic interval in sync ticks; 0 = off
- clr_cnt  in  1  synchronous clear of both counters
- trigger_out  out  5  issued event: [0] syn, [1] trg, [2] rsr, [3] res, [4] cal
- trigger_pos  out  4  sub-phase position of the issued event; 0 for non-ext events
- cnt_acc  out  CNT_W  issued trigger count
- cnt_lost  out  CNT_W  dropped trigger count
- dead  out  1  dead-time active

Behaviour:
- Reset: all outputs 0; sw_ready=1; FSM in IDLE; periodic counter 0.
- FSM is evaluated on sync=1 only. trigger_out, trigger_pos and dead are registered and held between sync ticks.
- IDLE:
  - trigger_out=0.
  - enable=1 -> RUN.
  - The periodic counter is held at 0 while in IDLE.
- RUN: select one request per tick. Priority is sw > ext > periodic.
  - sw request = pending & src_en[1].
  - ext request = ext_evt!=0 & src_en[0].
  - periodic request = fire & src_en[2].
  - busy=1 blocks ext and periodic only. sw still issues.
  - On issue: trigger_out=selected bits on the next sync tick (latency 1 tick). trigger_pos=ext_pos only for ext, else 0. Go to DEAD with dcnt=DEADTIME-1.
  - On no issue: trigger_out=0.
- DEAD:
  - trigger_out=0, dead=1.
  - dcnt decrements each tick. At dcnt=0 -> RUN (so exactly DEADTIME ticks are blocked).
- enable=0 in any state -> IDLE at the next sync tick. Any pending sw command is retained.
- sw holding register:
  - sw_valid is sampled on any clk80 edge while sw_ready=1. The command is latched and sw_ready drops.
  - sw_ready rises on the tick the command issues.
  - sw_valid while sw_ready=0 is ignored.
  - sw_cmd=0 is treated as a no-op: it is not latched.
- Lost trigger:
  - Counted when ext_evt[1] or a periodic fire is presented but not issued (DEAD, busy, or lower priority), with the source enabled and the FSM not in IDLE.
  - At most one increment per tick.
- Counters:
  - cnt_acc increments when an issued event has bit[1] set.
  - Both counters saturate at all-ones.
  - clr_cnt zeroes both, taking effect on any clk80 edge. clr_cnt has priority over a simultaneous increment.
- Periodic generator:
  - Counts sync ticks while in RUN/DEAD. fire=1 for one tick when count==per_period-1, then the count reloads 0.
  - Fire event is trg (bit[1]) only.
  - per_period=0 holds the count at 0 with no fire.
  - A lower per_period below the current count wraps the count to 0 next tick with no fire.
- Reset mid-DEAD or with sw pending: everything returns to reset values and the pending command is discarded.

Optional Feature:
- TRG_SCHED_PERIODIC_EN defined: periodic generator present as above.
- Undefined: generator and per_period logic removed, the periodic request is tied 0, and src_en[2] is ignored. cnt_lost then counts ext losses only.

Test Plan:
- enable=1, src_en=001, ext_evt=00010 with ext_pos=7 on one tick -> next tick trigger_out=00010, trigger_pos=7, cnt_acc=1, dead=1 for 3 ticks.
- Two ext triggers 2 ticks apart, DEADTIME=3 -> second dropped, cnt_acc=1, cnt_lost=1.
- sw_cmd=01000 strobed while busy=1 and an ext trigger arrives on the same tick -> trigger_out=01000, trigger_pos=0, ext counted lost, sw_ready returns to 1.
- per_period=10, src_en=100 for 100 ticks -> 10 trg events spaced 10 ticks; per_period=0 -> none.
- cnt_lost preset to all-ones by forcing losses -> it stays saturated; clr_cnt asserted on the same cycle as a loss -> cnt_lost=0.
- Assert reset during DEAD with sw pending -> trigger_out=0, sw_ready=1, FSM IDLE; after release with enable=1 the first ext trigger issues with no dead-time carry-over.
